// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file write path.
// Optional scoreboard feature is selected with the RF_WARB_SCOREBOARD_EN macro
// in rf_write_arbiter.
package rf_ctrl_pkg;

   localparam int RF_ADDR_W = 5;
   localparam int RF_DATA_W = 32;

   localparam logic [RF_ADDR_W-1:0] REG_ZERO = 5'd0;

   // One register-file write: destination and data.
   typedef struct packed {
      logic [RF_ADDR_W-1:0] rd;
      logic [RF_DATA_W-1:0] wd;
   } rf_wr_req_t;

endpackage : rf_ctrl_pkg

// File: rtl/rf_aux_fifo.sv
// Small synchronous FIFO buffering auxiliary (MDU / load return) write requests.
// DEPTH must be a power of two and at least 2; pointers carry one extra wrap bit
// so full and empty can be told apart without a separate count.
module rf_aux_fifo
   import rf_ctrl_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  rf_wr_req_t push_req,
   input  logic       pop,
   output rf_wr_req_t head,
   output logic       full,
   output logic       empty
);

   localparam int PTR_W = $clog2(DEPTH);

   rf_wr_req_t       mem [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign head  = mem[rd_ptr[PTR_W-1:0]];

   // Pointer update; a push into a full FIFO or a pop from an empty one is ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Storage write; entries need no reset because empty masks them.
   always_ff @(posedge clk) begin
      if (!rst && push && !full) begin
         mem[wr_ptr[PTR_W-1:0]] <= push_req;
      end
   end

endmodule : rf_aux_fifo

// File: rtl/rf_write_arbiter.sv
// Single write-port sequencer for the 32x32 register file.
// The writeback stage has fixed priority; auxiliary writes are buffered in
// rf_aux_fifo and protected from starvation by stalling the pipeline.
// Define RF_WARB_SCOREBOARD_EN to build the per-register busy scoreboard;
// otherwise busy_o is tied low and the reservation inputs are ignored.
module rf_write_arbiter
   import rf_ctrl_pkg::*;
#(
   parameter int AUX_DEPTH  = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pipe_we_i,
   input  logic [RF_ADDR_W-1:0] pipe_rd_i,
   input  logic [RF_DATA_W-1:0] pipe_wd_i,
   input  logic                 aux_valid_i,
   output logic                 aux_ready_o,
   input  logic [RF_ADDR_W-1:0] aux_rd_i,
   input  logic [RF_DATA_W-1:0] aux_wd_i,
   input  logic                 rsv_valid_i,
   input  logic [RF_ADDR_W-1:0] rsv_rd_i,
   output logic                 stall_pipe_o,
   output logic [31:0]          busy_o,
   output logic                 RegWrite_o,
   output logic [RF_ADDR_W-1:0] write_register_o,
   output logic [RF_DATA_W-1:0] write_data_register_o,
   output logic                 rd_blocked_o
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   rf_wr_req_t aux_head;
   rf_wr_req_t aux_req;
   rf_wr_req_t wr_next;
   rf_wr_req_t wr_q;
   logic       fifo_full;
   logic       fifo_empty;
   logic       aux_push;
   logic       aux_pop;
   logic       pipe_win;
   logic       we_next;
   logic       we_q;
   logic       stall_q;
   logic [3:0] starve_cnt;
   logic [3:0] starve_next;

   // Ready is forced low during reset so nothing is accepted into a FIFO being cleared.
   assign aux_ready_o = !fifo_full && !rst;
   assign aux_push    = aux_valid_i && aux_ready_o;
   assign aux_req     = '{rd: aux_rd_i, wd: aux_wd_i};

   // Pipe writes to r0 are dropped and leave the slot to the FIFO head.
   assign pipe_win = pipe_we_i && (pipe_rd_i != REG_ZERO);
   assign aux_pop  = !pipe_win && !fifo_empty;

   rf_aux_fifo #(
      .DEPTH (AUX_DEPTH)
   ) u_aux_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (aux_push),
      .push_req (aux_req),
      .pop      (aux_pop),
      .head     (aux_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Select the write issued next cycle; an r0 head is consumed without a write.
   always_comb begin
      we_next = 1'b0;
      wr_next = '0;
      if (pipe_win) begin
         we_next = 1'b1;
         wr_next = '{rd: pipe_rd_i, wd: pipe_wd_i};
      end else if (aux_pop && (aux_head.rd != REG_ZERO)) begin
         we_next = 1'b1;
         wr_next = aux_head;
      end
   end

   // Count cycles the head waits behind the pipe, saturating at the counter limit.
   always_comb begin
      starve_next = '0;
      if (!fifo_empty && !aux_pop) begin
         starve_next = (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
      end
   end

   // Registered write port, starvation counter and stall request.
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q       <= 1'b0;
         wr_q       <= '0;
         starve_cnt <= '0;
         stall_q    <= 1'b0;
      end else begin
         we_q       <= we_next;
         wr_q       <= wr_next;
         starve_cnt <= starve_next;
         stall_q    <= (starve_next >= STARVE_LIM);
      end
   end

   assign RegWrite_o            = we_q;
   assign write_register_o      = wr_q.rd;
   assign write_data_register_o = wr_q.wd;
   assign rd_blocked_o          = we_q;
   assign stall_pipe_o          = stall_q;

`ifdef RF_WARB_SCOREBOARD_EN
   logic [31:0] busy_q;
   logic [31:0] busy_set;
   logic [31:0] busy_clr;

   // Reservation sets a bit, an auxiliary pop clears it; set beats clear.
   always_comb begin
      busy_set = '0;
      busy_clr = '0;
      if (rsv_valid_i && (rsv_rd_i != REG_ZERO)) begin
         busy_set[rsv_rd_i] = 1'b1;
      end
      if (aux_pop) begin
         busy_clr[aux_head.rd] = 1'b1;
      end
   end

   // Busy bits register.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= (busy_q & ~busy_clr) | busy_set;
      end
   end

   assign busy_o = busy_q;
`else
   logic unused_rsv;
   assign unused_rsv = ^{rsv_valid_i, rsv_rd_i};
   assign busy_o     = '0;
`endif

   // The pipeline must not request a write while it is being stalled.
   a_stall_protocol : assert property (@(posedge clk) disable iff (rst)
      !(stall_pipe_o && pipe_we_i));

endmodule : rf_write_arbiter

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios followed by a
// randomized phase, all compared against a queue-based reference model.
module tb_rf_write_arbiter;
   import rf_ctrl_pkg::*;

   localparam int AUX_DEPTH  = 2;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_we_i;
   logic [4:0]  pipe_rd_i;
   logic [31:0] pipe_wd_i;
   logic        aux_valid_i;
   logic        aux_ready_o;
   logic [4:0]  aux_rd_i;
   logic [31:0] aux_wd_i;
   logic        rsv_valid_i;
   logic [4:0]  rsv_rd_i;
   logic        stall_pipe_o;
   logic [31:0] busy_o;
   logic        RegWrite_o;
   logic [4:0]  write_register_o;
   logic [31:0] write_data_register_o;
   logic        rd_blocked_o;

   int checks = 0;
   int errors = 0;

   // Reference model state
   rf_wr_req_t  modelQ[$];
   int          waitCnt = 0;
   logic        expWe = 1'b0;
   logic [4:0]  expAddr = '0;
   logic [31:0] expData = '0;
   logic        expStall = 1'b0;
   logic [31:0] expBusy = '0;

   rf_write_arbiter #(
      .AUX_DEPTH  (AUX_DEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .pipe_we_i             (pipe_we_i),
      .pipe_rd_i             (pipe_rd_i),
      .pipe_wd_i             (pipe_wd_i),
      .aux_valid_i           (aux_valid_i),
      .aux_ready_o           (aux_ready_o),
      .aux_rd_i              (aux_rd_i),
      .aux_wd_i              (aux_wd_i),
      .rsv_valid_i           (rsv_valid_i),
      .rsv_rd_i              (rsv_rd_i),
      .stall_pipe_o          (stall_pipe_o),
      .busy_o                (busy_o),
      .RegWrite_o            (RegWrite_o),
      .write_register_o      (write_register_o),
      .write_data_register_o (write_data_register_o),
      .rd_blocked_o          (rd_blocked_o)
   );

   // 10-unit clock
   always #5 clk = ~clk;

   // Direct comparison used for the scenario-specific expectations.
   task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Compare every registered output against the model after a clock edge.
   task automatic checkOutput();
      checks++;
      assert (RegWrite_o === expWe) else begin
         errors++;
         $error("[TB] FAIL RegWrite: observed %0b expected %0b", RegWrite_o, expWe);
      end
      checks++;
      assert (rd_blocked_o === expWe) else begin
         errors++;
         $error("[TB] FAIL rd_blocked: observed %0b expected %0b", rd_blocked_o, expWe);
      end
      checks++;
      assert (write_register_o === expAddr) else begin
         errors++;
         $error("[TB] FAIL write_register: observed %0d expected %0d", write_register_o, expAddr);
      end
      checks++;
      assert (write_data_register_o === expData) else begin
         errors++;
         $error("[TB] FAIL write_data: observed 0x%08h expected 0x%08h", write_data_register_o, expData);
      end
      checks++;
      assert (stall_pipe_o === expStall) else begin
         errors++;
         $error("[TB] FAIL stall_pipe: observed %0b expected %0b", stall_pipe_o, expStall);
      end
      checks++;
      assert (busy_o === expBusy) else begin
         errors++;
         $error("[TB] FAIL busy: observed 0x%08h expected 0x%08h", busy_o, expBusy);
      end
   endtask

   // Drive one cycle of inputs, check ready, advance the model across the edge, check outputs.
   task automatic applyStimulus(input logic r, input logic pwe, input logic [4:0] prd,
                                input logic [31:0] pwd, input logic av, input logic [4:0] ard,
                                input logic [31:0] awd, input logic rv, input logic [4:0] rrd);
      logic       modelReady;
      logic       pWin;
      logic       accept;
      rf_wr_req_t head;
      rf_wr_req_t newReq;
      rst         = r;
      pipe_we_i   = pwe && !expStall;
      pipe_rd_i   = prd;
      pipe_wd_i   = pwd;
      aux_valid_i = av;
      aux_rd_i    = ard;
      aux_wd_i    = awd;
      rsv_valid_i = rv;
      rsv_rd_i    = rrd;
      #1;
      modelReady = !r && (modelQ.size() < AUX_DEPTH);
      checks++;
      assert (aux_ready_o === modelReady) else begin
         errors++;
         $error("[TB] FAIL aux_ready: observed %0b expected %0b", aux_ready_o, modelReady);
      end
      @(posedge clk);
      if (r) begin
         modelQ.delete();
         waitCnt  = 0;
         expWe    = 1'b0;
         expAddr  = '0;
         expData  = '0;
         expStall = 1'b0;
         expBusy  = '0;
      end else begin
         pWin   = pipe_we_i && (pipe_rd_i != 5'd0);
         accept = av && modelReady;
         if (pWin) begin
            expWe   = 1'b1;
            expAddr = pipe_rd_i;
            expData = pwd;
            waitCnt = (modelQ.size() > 0) ? ((waitCnt < 15) ? waitCnt + 1 : 15) : 0;
         end else if (modelQ.size() > 0) begin
            head    = modelQ.pop_front();
            expWe   = (head.rd != 5'd0);
            expAddr = expWe ? head.rd : 5'd0;
            expData = expWe ? head.wd : 32'd0;
            waitCnt = 0;
`ifdef RF_WARB_SCOREBOARD_EN
            expBusy[head.rd] = 1'b0;
`endif
         end else begin
            expWe   = 1'b0;
            expAddr = '0;
            expData = '0;
            waitCnt = 0;
         end
`ifdef RF_WARB_SCOREBOARD_EN
         if (rv && (rrd != 5'd0)) begin
            expBusy[rrd] = 1'b1;
         end
`endif
         if (accept) begin
            newReq.rd = ard;
            newReq.wd = awd;
            modelQ.push_back(newReq);
         end
         expStall = (waitCnt >= STARVE_MAX);
      end
      @(negedge clk);
      checkOutput();
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
   endtask

   initial begin
      int stallStep;
      $display("[TB] starting rf_write_arbiter bench");
      @(negedge clk);

      // Reset response
      applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'd1, 1'b0, 5'd0);
      expectEq("reset_regwrite", {31'd0, RegWrite_o}, 32'd0);
      expectEq("reset_busy", busy_o, 32'd0);
      idleCycle();

      // Pipe write of r5
      applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      expectEq("pipe_we", {31'd0, RegWrite_o}, 32'd1);
      expectEq("pipe_addr", {27'd0, write_register_o}, 32'd5);
      expectEq("pipe_data", write_data_register_o, 32'hDEADBEEF);

      // Two queued writes with an idle pipe drain in order
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h11, 1'b0, 5'd0);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0);
      expectEq("aux_first_addr", {27'd0, write_register_o}, 32'd3);
      idleCycle();
      expectEq("aux_second_addr", {27'd0, write_register_o}, 32'd4);
      expectEq("aux_second_data", write_data_register_o, 32'h22);
      idleCycle();

      // Fill the FIFO behind the pipe, then a third push is held until space frees
      applyStimulus(1'b0, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0);
      applyStimulus(1'b0, 1'b1, 5'd1, 32'hA2, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0);
      applyStimulus(1'b0, 1'b1, 5'd1, 32'hA3, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0);
      expectEq("full_ready", {31'd0, aux_ready_o}, 32'd0);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0);
      idleCycle();
      expectEq("held_push_addr", {27'd0, write_register_o}, 32'd6);
      idleCycle();

      // Starvation: continuous pipe stream with one entry waiting
      stallStep = -1;
      applyStimulus(1'b0, 1'b1, 5'd1, 32'hB0, 1'b1, 5'd8, 32'h77, 1'b0, 5'd0);
      for (int i = 1; i <= 7; i++) begin
         applyStimulus(1'b0, 1'b1, 5'd1, 32'hB0 + i, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
         if (stall_pipe_o && stallStep < 0) begin
            stallStep = i;
         end
         if (i == STARVE_MAX + 1) begin
            expectEq("starve_aux_addr", {27'd0, write_register_o}, 32'd8);
            expectEq("starve_stall_fall", {31'd0, stall_pipe_o}, 32'd0);
         end
      end
      expectEq("starve_stall_step", stallStep, STARVE_MAX);
      idleCycle();

      // Register 0 handling
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h5A, 1'b0, 5'd0);
      applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'h99, 1'b0, 5'd0);
      expectEq("r0_aux_wins", {27'd0, write_register_o}, 32'd7);
      idleCycle();
      expectEq("r0_aux_dropped", {31'd0, RegWrite_o}, 32'd0);
      idleCycle();

`ifdef RF_WARB_SCOREBOARD_EN
      // Scoreboard set, clear, and set-wins-over-clear
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
      expectEq("sb_set", {31'd0, busy_o[9]}, 32'd1);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
      idleCycle();
      expectEq("sb_clear", {31'd0, busy_o[9]}, 32'd0);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9A, 1'b1, 5'd9);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
      expectEq("sb_set_wins", {31'd0, busy_o[9]}, 32'd1);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9B, 1'b0, 5'd0);
      idleCycle();
`endif

      // Mid-queue reset discards pending writes
      applyStimulus(1'b0, 1'b1, 5'd2, 32'hC1, 1'b1, 5'd10, 32'h10, 1'b1, 5'd12);
      applyStimulus(1'b0, 1'b1, 5'd2, 32'hC2, 1'b1, 5'd11, 32'h11, 1'b1, 5'd13);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      expectEq("midreset_busy", busy_o, 32'd0);
      idleCycle();
      expectEq("midreset_no_write", {31'd0, RegWrite_o}, 32'd0);
      idleCycle();

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 63) == 0),
                       1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 31)),
                       $urandom,
                       ($urandom_range(0, 9) < 6),
                       5'($urandom_range(0, 31)),
                       $urandom,
                       ($urandom_range(0, 9) < 3),
                       5'($urandom_range(0, 31)));
      end
      for (int i = 0; i < 4; i++) begin
         idleCycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_rf_write_arbiter
